register_writeback: RTL and testbench

- Write end of the integer register file: the writer for the two-port register read performed by instruction_decoder.
- Captures MEM-stage results in a WB pipeline register and selects write data (ALU, load-extended memory, PC+4).
- Owns the 32x32 register array. Exposes rs1/rs2 read ports with write-through bypass and a retired-instruction counter.

---
 rtl/register_writeback_if.sv | 35 +++
 rtl/register_writeback.sv | 92 +++++++++
 tb/tb_register_writeback.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/register_writeback_if.sv
// Bus between the MEM/WB boundary, decode read ports and the register file write end.
// The master side drives retiring results and read addresses; the slave is register_writeback.
interface register_writeback_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic            wb_valid;
   logic [AW-1:0]   wb_rd;
   logic [1:0]      wb_sel;
   logic [2:0]      wb_funct3;
   logic [1:0]      wb_addr_lo;
   logic [XLEN-1:0] alu_result;
   logic [XLEN-1:0] mem_rdata;
   logic [XLEN-1:0] pc_plus4;
   logic [AW-1:0]   rs1_addr;
   logic [AW-1:0]   rs2_addr;
   logic [XLEN-1:0] read_data1;
   logic [XLEN-1:0] read_data2;
   logic            rf_we;
   logic [AW-1:0]   rf_waddr;
   logic [XLEN-1:0] rf_wdata;
   logic [31:0]     retire_count;

   modport master (
      output wb_valid, wb_rd, wb_sel, wb_funct3, wb_addr_lo,
      output alu_result, mem_rdata, pc_plus4, rs1_addr, rs2_addr,
      input  read_data1, read_data2, rf_we, rf_waddr, rf_wdata, retire_count
   );

   modport slave (
      input  wb_valid, wb_rd, wb_sel, wb_funct3, wb_addr_lo,
      input  alu_result, mem_rdata, pc_plus4, rs1_addr, rs2_addr,
      output read_data1, read_data2, rf_we, rf_waddr, rf_wdata, retire_count
   );
endinterface

// File: rtl/register_writeback.sv
// Write-back stage and integer register file: WB pipeline register, load extraction,
// 32-entry array with write-through read bypass, and a retired-instruction counter.
module register_writeback #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   register_writeback_if.slave  bus
);
   localparam int AW = $clog2(NREGS);

   logic signed [XLEN-1:0] wb_data_p0;
   logic                   we_p1;
   logic [AW-1:0]          waddr_p1;
   logic signed [XLEN-1:0] wdata_p1;
   logic [31:0]            retire_cnt;
   logic [XLEN-1:0]        regs [NREGS];
   logic [XLEN-1:0]        rdata1;
   logic [XLEN-1:0]        rdata2;

   function automatic logic [XLEN-1:0] load_extract(
      input logic [2:0]      funct3,
      input logic [1:0]      offset,
      input logic [XLEN-1:0] word
   );
      logic [7:0]  byte_v;
      logic [15:0] half_v;
      byte_v = word[8*offset +: 8];
      half_v = offset[1] ? word[16 +: 16] : word[0 +: 16];
      case (funct3)
         3'b000:  load_extract = {{(XLEN-8){byte_v[7]}}, byte_v};
         3'b100:  load_extract = {{(XLEN-8){1'b0}}, byte_v};
         3'b001:  load_extract = {{(XLEN-16){half_v[15]}}, half_v};
         3'b101:  load_extract = {{(XLEN-16){1'b0}}, half_v};
         default: load_extract = word;
      endcase
   endfunction

   // p0: write-data select from the MEM-stage inputs
   always_comb begin
      wb_data_p0 = bus.alu_result;
      case (bus.wb_sel)
         2'b01:   wb_data_p0 = load_extract(bus.wb_funct3, bus.wb_addr_lo, bus.mem_rdata);
         2'b10:   wb_data_p0 = bus.pc_plus4;
         default: wb_data_p0 = bus.alu_result;
      endcase
   end

   // p1: WB register capture, then array commit one edge later; reset drops any pending write
   always_ff @(posedge clk) begin
      if (reset) begin
         we_p1      <= 1'b0;
         waddr_p1   <= '0;
         wdata_p1   <= '0;
         retire_cnt <= '0;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         we_p1 <= bus.wb_valid && (bus.wb_rd != '0);
         if (bus.wb_valid) begin
            waddr_p1   <= bus.wb_rd;
            wdata_p1   <= wb_data_p0;
            retire_cnt <= retire_cnt + 32'd1;
         end
         if (we_p1 && (waddr_p1 != '0)) regs[waddr_p1] <= wdata_p1;
      end
   end

   // read ports: x0 hardwired, then bypass of the not-yet-committed write
   always_comb begin
      rdata1 = regs[bus.rs1_addr];
      if (bus.rs1_addr == '0)
         rdata1 = '0;
      else if (we_p1 && (waddr_p1 == bus.rs1_addr))
         rdata1 = wdata_p1;
   end

   always_comb begin
      rdata2 = regs[bus.rs2_addr];
      if (bus.rs2_addr == '0)
         rdata2 = '0;
      else if (we_p1 && (waddr_p1 == bus.rs2_addr))
         rdata2 = wdata_p1;
   end

   assign bus.read_data1   = rdata1;
   assign bus.read_data2   = rdata2;
   assign bus.rf_we        = we_p1;
   assign bus.rf_waddr     = waddr_p1;
   assign bus.rf_wdata     = wdata_p1;
   assign bus.retire_count = retire_cnt;
endmodule

// File: tb/tb_register_writeback.sv
// Directed bench for register_writeback: expected WB-register contents are queued when a
// retiring instruction is driven and compared when the WB register presents it.
module tb_register_writeback;
   logic clk = 1'b0;
   logic reset = 1'b1;

   register_writeback_if bus ();

   register_writeback dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
   } wb_exp_t;

   wb_exp_t     sb [$];
   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_retire = 32'd0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                        input logic [1:0] lo, input logic [31:0] alu, input logic [31:0] mem,
                        input logic [31:0] pc, input logic [31:0] exp_data);
      wb_exp_t e;
      bus.wb_valid   = 1'b1;
      bus.wb_rd      = rd;
      bus.wb_sel     = sel;
      bus.wb_funct3  = f3;
      bus.wb_addr_lo = lo;
      bus.alu_result = alu;
      bus.mem_rdata  = mem;
      bus.pc_plus4   = pc;
      e.we   = (rd != 5'd0);
      e.addr = rd;
      e.data = exp_data;
      sb.push_back(e);
      exp_retire = exp_retire + 32'd1;
   endtask

   task automatic check_wb(input string tag);
      wb_exp_t e;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check({tag, "_we"}, {31'd0, bus.rf_we}, {31'd0, e.we});
         check({tag, "_waddr"}, {27'd0, bus.rf_waddr}, {27'd0, e.addr});
         check({tag, "_wdata"}, bus.rf_wdata, e.data);
      end
      check({tag, "_retire"}, bus.retire_count, exp_retire);
   endtask

   task automatic read_check(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                             input logic [31:0] e1, input logic [31:0] e2);
      bus.rs1_addr = a1;
      bus.rs2_addr = a2;
      #1;
      check({tag, "_rd1"}, bus.read_data1, e1);
      check({tag, "_rd2"}, bus.read_data2, e2);
   endtask

   logic [2:0]  ld_f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
   logic [1:0]  ld_off [5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0};
   logic [31:0] ld_exp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                               32'h0000_7F01, 32'h80FF_7F01};

   initial begin
      bus.wb_valid   = 1'b0;
      bus.wb_rd      = 5'd0;
      bus.wb_sel     = 2'b00;
      bus.wb_funct3  = 3'b000;
      bus.wb_addr_lo = 2'd0;
      bus.alu_result = 32'd0;
      bus.mem_rdata  = 32'd0;
      bus.pc_plus4   = 32'd0;
      bus.rs1_addr   = 5'd0;
      bus.rs2_addr   = 5'd0;

      // reset state
      step();
      step();
      reset = 1'b0;
      check("rst_we", {31'd0, bus.rf_we}, 32'd0);
      check("rst_retire", bus.retire_count, 32'd0);
      for (int a = 0; a < 32; a++)
         read_check("rst_read", 5'(a), 5'(31 - a), 32'd0, 32'd0);

      // ALU write, bypass then array
      drive(5'd5, 2'b00, 3'b000, 2'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'hDEAD_BEEF);
      step();
      bus.wb_valid = 1'b0;
      check_wb("alu5");
      read_check("alu5_bypass", 5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      step();
      check("alu5_we_clear", {31'd0, bus.rf_we}, 32'd0);
      read_check("alu5_array", 5'd5, 5'd0, 32'hDEAD_BEEF, 32'd0);

      // back-to-back load extraction
      for (int i = 0; i < 5; i++) begin
         drive(5'(10 + i), 2'b01, ld_f3[i], ld_off[i], 32'h5555_5555, 32'h80FF_7F01,
               32'h0, ld_exp[i]);
         step();
         check_wb("load");
      end
      bus.wb_valid = 1'b0;
      step();
      for (int i = 0; i < 5; i++)
         read_check("load_array", 5'(10 + i), 5'(10 + i), ld_exp[i], ld_exp[i]);

      // sel=11 is ALU; same rd back-to-back, later value wins
      drive(5'd9, 2'b11, 3'b000, 2'd0, 32'h1111_2222, 32'hFFFF_FFFF, 32'h8, 32'h1111_2222);
      step();
      check_wb("same_rd_a");
      drive(5'd9, 2'b00, 3'b000, 2'd0, 32'h3333_4444, 32'd0, 32'd0, 32'h3333_4444);
      step();
      bus.wb_valid = 1'b0;
      check_wb("same_rd_b");
      read_check("same_rd_bypass", 5'd9, 5'd9, 32'h3333_4444, 32'h3333_4444);
      step();
      read_check("same_rd_array", 5'd9, 5'd5, 32'h3333_4444, 32'hDEAD_BEEF);

      // write to x0
      drive(5'd0, 2'b00, 3'b000, 2'd0, 32'h1234_5678, 32'd0, 32'd0, 32'h1234_5678);
      step();
      bus.wb_valid = 1'b0;
      check_wb("x0");
      read_check("x0_read", 5'd0, 5'd0, 32'd0, 32'd0);
      step();
      read_check("x0_after", 5'd0, 5'd0, 32'd0, 32'd0);

      // pending link write dropped by reset
      drive(5'd7, 2'b10, 3'b000, 2'd0, 32'hAAAA_AAAA, 32'd0, 32'h0000_0104, 32'h0000_0104);
      step();
      check_wb("link");
      bus.wb_valid = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp_retire = 32'd0;
      check("rst2_we", {31'd0, bus.rf_we}, 32'd0);
      check("rst2_retire", bus.retire_count, 32'd0);
      read_check("rst2_x7", 5'd7, 5'd5, 32'd0, 32'd0);
      step();
      read_check("rst2_x7_later", 5'd7, 5'd9, 32'd0, 32'd0);

      // retire counter wrap via backdoor preload
      force dut.retire_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.retire_cnt;
      #1;
      check("wrap_preload", bus.retire_count, 32'hFFFF_FFFF);
      exp_retire = 32'hFFFF_FFFF;
      drive(5'd3, 2'b00, 3'b000, 2'd0, 32'h0000_0042, 32'd0, 32'd0, 32'h0000_0042);
      step();
      bus.wb_valid = 1'b0;
      check_wb("wrap");
      check("wrap_zero", bus.retire_count, 32'd0);
      step();
      read_check("wrap_x3", 5'd3, 5'd0, 32'h0000_0042, 32'd0);

      check("sb_drained", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
